// File: rtl/lc3b_types.sv
// lc3b_types -- shared constants for the request/grant logic of the lc3b slice.
//
// Holds the request-vector width used by default wherever a priority
// encoder is instantiated, so every user of the encoder agrees on the
// same width without repeating the literal.
package lc3b_types;

  // Default number of request lines seen by a priority encoder.
  localparam int PE_DEFAULT_WIDTH = 8;

endpackage : lc3b_types

// File: rtl/pri_enc_core.sv
// pri_enc_core -- purely combinational lowest-index search.
//
// Finds the lowest-numbered asserted bit of req. Bit 0 has the highest
// priority. When no bit is set, idx is 0 and found is 0, so the result
// never carries a stale or undefined index.
//
// Ports:
//   req   [WIDTH-1:0]  request vector, bit k is request k
//   idx   [OUT_W-1:0]  index of the winning request (0 when none)
//   found              high when at least one request is asserted
module pri_enc_core #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [OUT_W-1:0] idx,
  output logic             found
);

  // Scan from the top bit downwards so that the last hit, which is the
  // lowest-index asserted bit, is the one left in idx.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = OUT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule : pri_enc_core

// File: rtl/priority_encoder.sv
// priority_encoder -- enable-gated priority encoder with registered copy.
//
// The lowest-index asserted request wins. binary_out and V are
// combinational (zero latency, independent of clk and reset);
// binary_out_q and V_q are the same values captured on each rising clk
// edge and cleared asynchronously while reset is high.
//
// Optional feature: define PRIORITY_ENCODER_ONEHOT_EN to add the onehot_out
// port, a one-hot decode of the winning index (all-zero when V is low).
//
// Ports:
//   clk                       rising-edge clock for the output registers
//   reset                     asynchronous, active-high clear of the registers
//   in            [WIDTH-1:0] request vector, bit k is request k
//   enable                    when low, no request is recognised
//   binary_out    [OUT_W-1:0] combinational index of the winning request
//   V                         combinational valid
//   binary_out_q  [OUT_W-1:0] binary_out registered one cycle
//   V_q                       V registered one cycle
//   onehot_out    [WIDTH-1:0] one-hot grant (PRIORITY_ENCODER_ONEHOT_EN only)
module priority_encoder
  import lc3b_types::*;
#(
  parameter int WIDTH = PE_DEFAULT_WIDTH,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  output logic [OUT_W-1:0] binary_out,
  output logic             V,
  output logic [OUT_W-1:0] binary_out_q,
  output logic             V_q
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] onehot_out
`endif
);

  logic [WIDTH-1:0] gated_req;
  logic [OUT_W-1:0] core_idx;
  logic             core_found;

  // Masking the requests before the search means a disabled encoder looks
  // exactly like one with no requests: index 0 and valid low.
  always_comb begin
    gated_req = enable ? in : '0;
  end

  pri_enc_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .req   (gated_req),
    .idx   (core_idx),
    .found (core_found)
  );

  always_comb begin
    binary_out = core_idx;
    V          = core_found;
  end

  // Registered copy of the combinational result; reset clears it at once
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      binary_out_q <= '0;
      V_q          <= 1'b0;
    end else begin
      binary_out_q <= binary_out;
      V_q          <= V;
    end
  end

`ifdef PRIORITY_ENCODER_ONEHOT_EN
  // The shift alone would give bit 0 set when nothing is valid, so the
  // decode is forced to zero whenever V is low.
  always_comb begin
    onehot_out = '0;
    if (V) begin
      onehot_out = {{(WIDTH - 1){1'b0}}, 1'b1} << binary_out;
    end
  end
`endif

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder -- self-checking bench for priority_encoder (WIDTH=8).
//
// Combinational outputs are compared against a reference model right after
// each stimulus; the expected registered values are queued at the same time
// and popped after the following rising edge.
module tb_priority_encoder;

  localparam int WIDTH = 8;
  localparam int OUT_W = 3;

  typedef struct {
    logic [OUT_W-1:0] bin;
    logic             v;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             enable;
  logic [OUT_W-1:0] binary_out;
  logic             V;
  logic [OUT_W-1:0] binary_out_q;
  logic             V_q;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] onehot_out;
`endif

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  priority_encoder #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .enable       (enable),
    .binary_out   (binary_out),
    .V            (V),
    .binary_out_q (binary_out_q),
    .V_q          (V_q)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    ,
    .onehot_out   (onehot_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ascending scan, first set bit wins.
  function automatic exp_t model(input logic [WIDTH-1:0] req, input logic en);
    exp_t r;
    r.bin = '0;
    r.v   = 1'b0;
    if (en) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (req[k]) begin
          r.bin = OUT_W'(k);
          r.v   = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: in=%b enable=%b got %0h expected %0h",
               tag, in, enable, actual, expected);
    end
  endtask

  // Drive one stimulus after a falling edge, check the combinational
  // outputs, queue the registered expectation and check it after the edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] req, input logic en,
                               input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in     = req;
    enable = en;
    #1;
    e = model(req, en);
    checkOutput({tag, "_bin"}, 64'(binary_out), 64'(e.bin));
    checkOutput({tag, "_v"}, 64'(V), 64'(e.v));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    checkOutput({tag, "_onehot"}, 64'(onehot_out),
                e.v ? (64'd1 << e.bin) : 64'd0);
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      checkOutput({tag, "_bin_q"}, 64'(binary_out_q), 64'(got.bin));
      checkOutput({tag, "_v_q"}, 64'(V_q), 64'(got.v));
    end
  endtask

  initial begin
    reset  = 1'b1;
    in     = '0;
    enable = 1'b0;
    #1;
    checkOutput("reset_bin_q", 64'(binary_out_q), 64'd0);
    checkOutput("reset_v_q", 64'(V_q), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed patterns.
    applyStimulus(8'b0000_1100, 1'b1, "in0c");
    checkOutput("in0c_bin_q_is2", 64'(binary_out_q), 64'd2);
    checkOutput("in0c_v_q_is1", 64'(V_q), 64'd1);
    applyStimulus(8'b1000_0000, 1'b1, "in80");
    applyStimulus(8'b1111_1111, 1'b1, "inff");
    applyStimulus(8'b0000_0000, 1'b1, "in00");
    applyStimulus(8'b0000_0101, 1'b0, "dis05");
    applyStimulus(8'b1111_1111, 1'b0, "disff");
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    @(negedge clk);
    in = 8'b0011_0000; enable = 1'b1;
    #1;
    checkOutput("onehot_30", 64'(onehot_out), 64'h10);
    in = 8'b0000_0000;
    #1;
    checkOutput("onehot_00", 64'(onehot_out), 64'h00);
`endif

    // Registered hold of 5, then asynchronous reset mid-cycle.
    applyStimulus(8'b0010_0000, 1'b1, "in20");
    checkOutput("hold5_bin_q", 64'(binary_out_q), 64'd5);
    @(negedge clk);
    in = 8'b0000_0010;
    #1;
    checkOutput("midcycle_hold_bin_q", 64'(binary_out_q), 64'd5);
    checkOutput("midcycle_hold_v_q", 64'(V_q), 64'd1);
    in = 8'b0010_0000;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_bin_q", 64'(binary_out_q), 64'd0);
    checkOutput("async_reset_v_q", 64'(V_q), 64'd0);
    checkOutput("reset_comb_bin", 64'(binary_out), 64'd5);
    checkOutput("reset_comb_v", 64'(V), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("reset_held_bin_q", 64'(binary_out_q), 64'd0);
    checkOutput("reset_held_v_q", 64'(V_q), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("release_wait_v_q", 64'(V_q), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("release_reload_bin_q", 64'(binary_out_q), 64'd5);
    checkOutput("release_reload_v_q", 64'(V_q), 64'd1);

    // Exhaustive sweep with enable high.
    for (int n = 0; n < 256; n++) begin
      applyStimulus(8'(n), 1'b1, "sweep");
    end

    // A few random patterns with random enable.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'($urandom_range(255)), 1'($urandom_range(1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_priority_encoder
